// File: rtl/pixel_frame_sink.sv
// Sink for the processed pixel stream: FIFO for a polled reader, frame position tracking, per-frame checksum.
// Latency: rd_data/rd_valid 1 cycle after rd_en; frame_done/checksum 1 cycle after the last pixel of a frame.
// Backpressure: none on the pixel input (never stalls); pixels arriving while full without a pop are dropped and flagged.
module pixel_frame_sink #(
    parameter int DEPTH   = 16,
    parameter int FRAME_W = 32,
    parameter int FRAME_H = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       pixel_valid,
    input  logic [7:0]                 pixel_in,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       frame_done,
    output logic [15:0]                checksum,
    output logic [7:0]                 frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int RW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          wr;
    logic          rd;
    logic          drop;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [15:0]   acc;
    logic          last_col;
    logic          last_row;
    logic          eof;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a pixel when rd_en is high.
    always_comb begin
        wr        = pixel_valid && (!full || rd_en);
        rd        = rd_en && !empty;
        drop      = pixel_valid && !wr;
        level_nxt = level + LW'(wr) - LW'(rd);
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= pixel_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            rd_valid <= rd;
            level    <= level_nxt;
            full     <= (level_nxt == LW'(DEPTH));
            empty    <= (level_nxt == '0);
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        last_col = (col == CW'(FRAME_W - 1));
        last_row = (row == RW'(FRAME_H - 1));
        eof      = pixel_valid && last_col && last_row;
    end

    // Position and checksum advance on every strobe, dropped pixels included.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col        <= '0;
            row        <= '0;
            acc        <= '0;
            checksum   <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= eof;
            if (eof) begin
                checksum  <= acc + {8'd0, pixel_in};
                acc       <= '0;
                col       <= '0;
                row       <= '0;
                frame_cnt <= frame_cnt + 1'b1;
            end else if (pixel_valid) begin
                acc <= acc + {8'd0, pixel_in};
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_sink.sv
// Directed bench for pixel_frame_sink: default-size instance plus a 2x1-frame instance for frame_cnt wrap.
module tb_pixel_frame_sink;

    logic        clk;
    logic        resetn;
    logic        pv;
    logic [7:0]  px;
    logic        rd_en;
    logic        clr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic        frame_done;
    logic [15:0] checksum;
    logic [7:0]  frame_cnt;

    logic        pv2;
    logic [7:0]  px2;
    logic [7:0]  rd_data2;
    logic        rd_valid2;
    logic        empty2;
    logic        full2;
    logic [4:0]  level2;
    logic        overflow2;
    logic        frame_done2;
    logic [15:0] checksum2;
    logic [7:0]  frame_cnt2;

    int n_chk;
    int n_fail;
    int cyc;
    int rd_cnt;
    int fd_cnt;
    int fd_cyc;
    int fd2_cnt;
    int last_cyc;
    logic [7:0] exp_q[$];

    pixel_frame_sink #(.DEPTH(16), .FRAME_W(32), .FRAME_H(32)) dut (
        .clk(clk), .resetn(resetn), .pixel_valid(pv), .pixel_in(px), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .clr_ovf(clr), .frame_done(frame_done), .checksum(checksum),
        .frame_cnt(frame_cnt)
    );

    pixel_frame_sink #(.DEPTH(16), .FRAME_W(2), .FRAME_H(1)) dut2 (
        .clk(clk), .resetn(resetn), .pixel_valid(pv2), .pixel_in(px2), .rd_en(1'b0),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .empty(empty2), .full(full2), .level(level2),
        .overflow(overflow2), .clr_ovf(1'b0), .frame_done(frame_done2), .checksum(checksum2),
        .frame_cnt(frame_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock; observe outputs 1 time unit after the rising edge and score any popped pixel.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_valid) begin
            rd_cnt++;
            if (exp_q.size() == 0) chk("rd_unexpected_pop", exp_q.size(), 1);
            else chk("rd_data_order", rd_data, exp_q.pop_front());
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (frame_done2) fd2_cnt++;
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_rd_data"}, rd_data, 0);
        chk({pfx, "_rd_valid"}, rd_valid, 0);
        chk({pfx, "_empty"}, empty, 1);
        chk({pfx, "_full"}, full, 0);
        chk({pfx, "_level"}, level, 0);
        chk({pfx, "_overflow"}, overflow, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_checksum"}, checksum, 0);
        chk({pfx, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // 1024-pixel ramp i[7:0] with the reader popping every cycle, then drain.
    task automatic ramp(input string pfx);
        exp_q.delete();
        rd_cnt = 0;
        fd_cnt = 0;
        rd_en  = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            pv = 1'b1;
            px = i[7:0];
            exp_q.push_back(i[7:0]);
            step();
            if (i == 1022) chk({pfx, "_fd_early"}, fd_cnt, 0);
        end
        last_cyc = cyc;
        pv = 1'b0;
        chk({pfx, "_fd_cnt"}, fd_cnt, 1);
        chk({pfx, "_fd_cyc"}, fd_cyc, last_cyc);
        repeat (4) step();
        rd_en = 1'b0;
        chk({pfx, "_fd_pulse_end"}, frame_done, 0);
        chk({pfx, "_rd_cnt"}, rd_cnt, 1024);
        chk({pfx, "_q_left"}, exp_q.size(), 0);
        chk({pfx, "_checksum"}, checksum, 16'hFE00);
        chk({pfx, "_frame_cnt"}, frame_cnt, 1);
        chk({pfx, "_overflow"}, overflow, 0);
        chk({pfx, "_empty"}, empty, 1);
        chk({pfx, "_level"}, level, 0);
    endtask

    task automatic fill16(input int base);
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pv = 1'b1;
            px = 8'(base + i);
            exp_q.push_back(8'(base + i));
            step();
        end
        pv = 1'b0;
    endtask

    task automatic drain();
        rd_en = 1'b1;
        repeat (18) step();
        rd_en = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; rd_cnt = 0; fd_cnt = 0; fd_cyc = 0; fd2_cnt = 0;
        resetn = 1'b0; pv = 1'b0; px = 8'd0; rd_en = 1'b0; clr = 1'b0; pv2 = 1'b0; px2 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        resetn = 1'b1;

        // Ramp frame
        ramp("t1");

        // Overflow: 20 pixels without reading
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            pv = 1'b1;
            px = i[7:0];
            step();
            if (i == 15) begin
                chk("t2_full", full, 1);
                chk("t2_level", level, 16);
                chk("t2_ovf_not_yet", overflow, 0);
            end
            if (i == 16) chk("t2_ovf_set", overflow, 1);
        end
        pv = 1'b0;
        for (int k = 0; k < 16; k++) exp_q.push_back(k[7:0]);
        rd_cnt = 0;
        drain();
        chk("t2_rd_cnt", rd_cnt, 16);
        chk("t2_q_left", exp_q.size(), 0);
        chk("t2_empty", empty, 1);
        chk("t2_full_clr", full, 0);

        // Clear alone, then pop while empty
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr_alone", overflow, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("t4_empty_rd_valid", rd_valid, 0);
        chk("t4_empty_level", level, 0);
        chk("t4_empty_flag", empty, 1);

        // Full with simultaneous push and pop
        fill16(100);
        chk("t3_full", full, 1);
        rd_en = 1'b1;
        for (int i = 116; i <= 120; i++) begin
            pv = 1'b1;
            px = i[7:0];
            exp_q.push_back(i[7:0]);
            step();
            chk("t3_level", level, 16);
            chk("t3_no_ovf", overflow, 0);
        end
        pv = 1'b0;
        drain();
        chk("t3_q_left", exp_q.size(), 0);
        chk("t3_empty", empty, 1);
        chk("t3_ovf_end", overflow, 0);

        // Drop and clear in the same cycle: set wins
        fill16(200);
        pv = 1'b1; px = 8'd99; clr = 1'b1;
        step();
        pv = 1'b0; clr = 1'b0;
        chk("t4_set_wins", overflow, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr_after", overflow, 0);
        drain();
        chk("t4_q_left", exp_q.size(), 0);

        // Reset mid-frame
        exp_q.delete();
        rd_en = 1'b0;
        for (int i = 0; i < 500; i++) begin
            pv = 1'b1;
            px = 8'(i + 7);
            step();
        end
        pv = 1'b0;
        chk("t5_pre_ovf", overflow, 1);
        chk("t5_pre_level", level, 16);
        resetn = 1'b0;
        #2;
        reset_checks("t5_rst");
        step();
        resetn = 1'b1;
        ramp("t5");

        // frame_cnt wrap on the 2x1 instance
        fd2_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            pv2 = 1'b1;
            px2 = i[7:0];
            step();
        end
        pv2 = 1'b0;
        step();
        chk("t6_fd_cnt", fd2_cnt, 256);
        chk("t6_frame_cnt", frame_cnt2, 0);
        chk("t6_checksum", checksum2, 16'd509);
        chk("t6_level", level2, 16);
        chk("t6_full", full2, 1);
        chk("t6_empty", empty2, 0);
        chk("t6_overflow", overflow2, 1);
        chk("t6_rd_valid", rd_valid2, 0);
        chk("t6_rd_data", rd_data2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
